// File: rtl/bnn_param_loader_if.sv
// ---------------------------------------------------------------------------
// bnn_param_loader_if
// Handshake and write-bus bundle for the BNN parameter loader.
//   cmd_*        : region command handshake (host -> loader)
//   in_*         : parameter data beat handshake (host -> loader)
//   wr_*         : parameter memory write port (loader -> memories)
//   load_done    : one-cycle pulse when a region finishes loading
//   loaded_mask  : per-region loaded flags
//   params_ready : all six regions loaded
//   cmd_err      : sticky illegal-region flag
// The master modport is the host side, the slave modport is the loader.
// ---------------------------------------------------------------------------
interface bnn_param_loader_if #(
    parameter int K    = 5,
    parameter int HI_W = 6,
    parameter int LO_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_region;
    logic              in_valid;
    logic              in_ready;
    logic [K*K-1:0]    in_data;
    logic              wr_en;
    logic [2:0]        wr_region;
    logic [HI_W-1:0]   wr_hi;
    logic [LO_W-1:0]   wr_lo;
    logic [K*K-1:0]    wr_data;
    logic              load_done;
    logic [5:0]        loaded_mask;
    logic              params_ready;
    logic              cmd_err;

    modport master (
        output cmd_valid, cmd_region, in_valid, in_data,
        input  cmd_ready, in_ready, wr_en, wr_region, wr_hi, wr_lo, wr_data,
               load_done, loaded_mask, params_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_region, in_valid, in_data,
        output cmd_ready, in_ready, wr_en, wr_region, wr_hi, wr_lo, wr_data,
               load_done, loaded_mask, params_ready, cmd_err
    );
endinterface

// File: rtl/bnn_param_loader.sv
// ---------------------------------------------------------------------------
// bnn_param_loader
// Streams binarized-network parameters into six memory regions. A region
// command selects the target; the loader then accepts exactly N data beats,
// turning each into one registered memory write addressed by an outer (hi)
// and inner (lo) index, and raises load_done when the region is complete.
// Ports:
//   clk  : sole clock
//   rst  : synchronous active-high reset
//   bus  : bnn_param_loader_if.slave (command, data beat, write bus, status)
// ---------------------------------------------------------------------------
module bnn_param_loader #(
    parameter int K      = 5,
    parameter int C1_IN  = 5,
    parameter int C1_OUT = 18,
    parameter int C2_OUT = 60,
    parameter int FC_IN  = 960,
    parameter int FC_OUT = 10,
    parameter int FCB_W  = 16,
    parameter int OFF1_W = 7,
    parameter int OFF2_W = 9,
    parameter int MULT_W = 8,
    parameter int HI_W   = 6,
    parameter int LO_W   = 6
) (
    input logic              clk,
    input logic              rst,
    bnn_param_loader_if.slave bus
);

    localparam int DW = K * K;

    // Beat totals per region.
    localparam int N0 = C1_OUT * C1_IN;
    localparam int N1 = C2_OUT * C1_OUT;
    localparam int N2 = FC_OUT * FC_IN / FCB_W;
    localparam int N3 = C1_OUT;
    localparam int N4 = C2_OUT;
    localparam int N5 = FC_OUT;

    localparam int NMAX_A = (N0 > N1) ? N0 : N1;
    localparam int NMAX_B = (N2 > NMAX_A) ? N2 : NMAX_A;
    localparam int NMAX_C = (N3 > NMAX_B) ? N3 : NMAX_B;
    localparam int NMAX_D = (N4 > NMAX_C) ? N4 : NMAX_C;
    localparam int NMAX   = (N5 > NMAX_D) ? N5 : NMAX_D;

    // Beat counter must be able to hold NMAX itself, not just NMAX-1.
    localparam int CNT_W = $clog2(NMAX + 1);

    localparam logic [DW-1:0] FCB_MASK  = DW'((64'd1 << FCB_W) - 64'd1);
    localparam logic [DW-1:0] OFF1_MASK = DW'((64'd1 << OFF1_W) - 64'd1);
    localparam logic [DW-1:0] OFF2_MASK = DW'((64'd1 << OFF2_W) - 64'd1);
    localparam logic [DW-1:0] MULT_MASK = DW'((64'd1 << MULT_W) - 64'd1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        region_q, region_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [LO_W-1:0]   lo_q, lo_d;
    logic [LO_W:0]     lo_lim_q, lo_lim_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              wr_en_q, wr_en_d;
    logic [2:0]        wr_region_q, wr_region_d;
    logic [HI_W-1:0]   wr_hi_q, wr_hi_d;
    logic [LO_W-1:0]   wr_lo_q, wr_lo_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic              load_done_q, load_done_d;
    logic [5:0]        mask_q, mask_d;
    logic              err_q, err_d;

    logic              cmd_fire;
    logic              beat_fire;
    logic [LO_W:0]     lo_inc;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DW-1:0]     data_sel;

    assign cmd_fire  = bus.cmd_valid && (state_q == IDLE);
    assign beat_fire = bus.in_valid && (state_q == LOAD);
    assign lo_inc    = {1'b0, lo_q} + (LO_W + 1)'(1);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // Narrow regions keep only their low payload bits; everything above is zeroed.
    always_comb begin
        data_sel = bus.in_data;
        case (region_q)
            3'd2:    data_sel = bus.in_data & FCB_MASK;
            3'd3:    data_sel = bus.in_data & OFF1_MASK;
            3'd4:    data_sel = bus.in_data & OFF2_MASK;
            3'd5:    data_sel = bus.in_data & MULT_MASK;
            default: data_sel = bus.in_data;
        endcase
    end

    // Next-state logic: command decode in IDLE, beat counting and write
    // generation in LOAD, a single completion cycle in DONE.
    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        lo_lim_d    = lo_lim_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        wr_en_d     = 1'b0;
        wr_region_d = wr_region_q;
        wr_hi_d     = wr_hi_q;
        wr_lo_d     = wr_lo_q;
        wr_data_d   = wr_data_q;
        load_done_d = 1'b0;
        mask_d      = mask_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (bus.cmd_region > 3'd5) begin
                        err_d = 1'b1;
                    end else begin
                        state_d  = LOAD;
                        region_d = bus.cmd_region;
                        hi_d     = '0;
                        lo_d     = '0;
                        cnt_d    = '0;
                        mask_d[bus.cmd_region] = 1'b0;
                        case (bus.cmd_region)
                            3'd0:    begin total_d = CNT_W'(N0); lo_lim_d = (LO_W + 1)'(C1_IN);         end
                            3'd1:    begin total_d = CNT_W'(N1); lo_lim_d = (LO_W + 1)'(C1_OUT);        end
                            3'd2:    begin total_d = CNT_W'(N2); lo_lim_d = (LO_W + 1)'(FC_IN / FCB_W); end
                            3'd3:    begin total_d = CNT_W'(N3); lo_lim_d = (LO_W + 1)'(1);             end
                            3'd4:    begin total_d = CNT_W'(N4); lo_lim_d = (LO_W + 1)'(1);             end
                            default: begin total_d = CNT_W'(N5); lo_lim_d = (LO_W + 1)'(1);             end
                        endcase
                    end
                end
            end
            LOAD: begin
                if (beat_fire) begin
                    wr_en_d     = 1'b1;
                    wr_region_d = region_q;
                    wr_hi_d     = hi_q;
                    wr_lo_d     = lo_q;
                    wr_data_d   = data_sel;
                    cnt_d       = cnt_inc;
                    if (lo_inc == lo_lim_q) begin
                        lo_d = '0;
                        hi_d = hi_q + HI_W'(1);
                    end else begin
                        lo_d = lo_inc[LO_W-1:0];
                    end
                    if (cnt_inc == total_q) begin
                        state_d          = DONE;
                        load_done_d      = 1'b1;
                        mask_d[region_q] = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            region_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            lo_lim_q    <= '0;
            cnt_q       <= '0;
            total_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_region_q <= '0;
            wr_hi_q     <= '0;
            wr_lo_q     <= '0;
            wr_data_q   <= '0;
            load_done_q <= 1'b0;
            mask_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            lo_lim_q    <= lo_lim_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            wr_en_q     <= wr_en_d;
            wr_region_q <= wr_region_d;
            wr_hi_q     <= wr_hi_d;
            wr_lo_q     <= wr_lo_d;
            wr_data_q   <= wr_data_d;
            load_done_q <= load_done_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.in_ready     = (state_q == LOAD);
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_region    = wr_region_q;
    assign bus.wr_hi        = wr_hi_q;
    assign bus.wr_lo        = wr_lo_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.load_done    = load_done_q;
    assign bus.loaded_mask  = mask_q;
    assign bus.params_ready = &mask_q;
    assign bus.cmd_err      = err_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// ---------------------------------------------------------------------------
// tb_bnn_param_loader
// Directed bench for bnn_param_loader: reset state, every region's beat
// count and hi/lo walk, payload masking, stalls, illegal commands, reset
// during a load, and params_ready across a reload.
// ---------------------------------------------------------------------------
module tb_bnn_param_loader;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;
    int cur_r;
    int cur_i;
    logic [5:0] exp_mask;
    logic       exp_err;

    bnn_param_loader_if #(.K(5), .HI_W(6), .LO_W(6)) bus ();

    bnn_param_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge so outputs are stable when sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s (region %0d beat %0d): observed 0x%0h expected 0x%0h",
                   tag, cur_r, cur_i, obs, exp);
        end
    endtask

    function automatic logic [24:0] beat_pattern(input int i, input logic [24:0] x);
        return 25'(i) ^ x;
    endfunction

    // Offer one region command for a single cycle.
    task automatic apply_stimulus(input logic [2:0] region);
        bus.cmd_valid  = 1'b1;
        bus.cmd_region = region;
        tick();
        bus.cmd_valid  = 1'b0;
    endtask

    // Full region load: command, n beats (optionally stalled), DONE cycle.
    // lo_lim and width describe the expected address walk and payload width.
    // abort_at >= 0 asserts rst together with that beat and ends the load.
    task automatic load_region(input int region, input int n, input int lo_lim,
                               input int width, input int stall_mod,
                               input logic [24:0] pat_x, input int abort_at);
        int writes;
        logic [24:0] m;
        logic [24:0] pat;
        writes = 0;
        cur_r  = region;
        cur_i  = -1;
        m = (width >= 25) ? 25'h1FFFFFF : 25'((32'd1 << width) - 32'd1);

        apply_stimulus(3'(region));
        exp_mask[region] = 1'b0;
        check_output("in_ready_after_cmd", 32'(bus.in_ready), 32'd1);
        check_output("cmd_ready_in_load", 32'(bus.cmd_ready), 32'd0);
        check_output("mask_cleared", 32'(bus.loaded_mask), 32'(exp_mask));
        check_output("params_ready_load", 32'(bus.params_ready), 32'(&exp_mask));

        for (int i = 0; i < n; i++) begin
            cur_i = i;
            pat = beat_pattern(i, pat_x);
            if (i == abort_at) begin
                rst         = 1'b1;
                bus.in_valid = 1'b1;
                bus.in_data  = pat;
                tick();
                rst          = 1'b0;
                bus.in_valid = 1'b0;
                exp_mask     = 6'b0;
                exp_err      = 1'b0;
                check_output("abort_wr_en", 32'(bus.wr_en), 32'd0);
                check_output("abort_mask", 32'(bus.loaded_mask), 32'd0);
                check_output("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
                check_output("abort_in_ready", 32'(bus.in_ready), 32'd0);
                check_output("abort_cmd_err", 32'(bus.cmd_err), 32'd0);
                return;
            end
            if (stall_mod > 0 && (i % stall_mod) == 2) begin
                for (int s = 0; s <= (i % 3); s++) begin
                    bus.in_valid = 1'b0;
                    tick();
                    check_output("stall_wr_en", 32'(bus.wr_en), 32'd0);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = pat;
            tick();
            if (bus.wr_en === 1'b1) writes++;
            check_output("wr_en", 32'(bus.wr_en), 32'd1);
            check_output("wr_region", 32'(bus.wr_region), 32'(region));
            check_output("wr_hi", 32'(bus.wr_hi), 32'(i / lo_lim));
            check_output("wr_lo", 32'(bus.wr_lo), 32'(i % lo_lim));
            check_output("wr_data", 32'(bus.wr_data), 32'(pat & m));
            if (i == n - 1) begin
                exp_mask[region] = 1'b1;
                check_output("load_done", 32'(bus.load_done), 32'd1);
                check_output("in_ready_done", 32'(bus.in_ready), 32'd0);
            end else begin
                check_output("load_done_early", 32'(bus.load_done), 32'd0);
            end
            check_output("loaded_mask", 32'(bus.loaded_mask), 32'(exp_mask));
            check_output("params_ready", 32'(bus.params_ready), 32'(&exp_mask));
        end

        // Keep offering a beat through the DONE cycle; it must be ignored.
        cur_i = n;
        bus.in_data = 25'h1555555;
        tick();
        bus.in_valid = 1'b0;
        check_output("done_no_write", 32'(bus.wr_en), 32'd0);
        check_output("back_to_idle", 32'(bus.cmd_ready), 32'd1);
        check_output("load_done_pulse", 32'(bus.load_done), 32'd0);
        check_output("write_count", 32'(writes), 32'(n));
        check_output("cmd_err_hold", 32'(bus.cmd_err), 32'(exp_err));
    endtask

    task automatic illegal_cmd(input logic [2:0] region);
        cur_r = int'(region);
        cur_i = -1;
        apply_stimulus(region);
        exp_err = 1'b1;
        check_output("illegal_cmd_err", 32'(bus.cmd_err), 32'd1);
        check_output("illegal_stays_idle", 32'(bus.cmd_ready), 32'd1);
        check_output("illegal_no_load", 32'(bus.in_ready), 32'd0);
        check_output("illegal_mask", 32'(bus.loaded_mask), 32'(exp_mask));
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        cur_r          = -1;
        cur_i          = -1;
        exp_mask       = 6'b0;
        exp_err        = 1'b0;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_region = 3'd0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;

        // Reset state, with a handshake offered to confirm reset wins.
        bus.cmd_valid = 1'b1;
        tick();
        tick();
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        check_output("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check_output("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check_output("rst_wr_hi", 32'(bus.wr_hi), 32'd0);
        check_output("rst_load_done", 32'(bus.load_done), 32'd0);
        check_output("rst_mask", 32'(bus.loaded_mask), 32'd0);
        check_output("rst_params_ready", 32'(bus.params_ready), 32'd0);
        check_output("rst_cmd_err", 32'(bus.cmd_err), 32'd0);

        // Data offered while idle produces no write.
        bus.in_valid = 1'b1;
        bus.in_data  = 25'h1FFFFFF;
        tick();
        bus.in_valid = 1'b0;
        check_output("idle_no_write", 32'(bus.wr_en), 32'd0);
        check_output("idle_stays", 32'(bus.cmd_ready), 32'd1);

        // conv1 offsets: in_data = i, 18 beats, lo fixed at 0.
        load_region(3, 18, 1, 7, 0, 25'h0, -1);
        check_output("mask_after_r3", 32'(bus.loaded_mask), 32'h08);

        // conv1 kernels with stalls.
        load_region(0, 90, 5, 25, 7, 25'h1A5A5A5, -1);

        // fc binary weights: lo wraps at 59, hi reaches 9, upper bits zero.
        load_region(2, 600, 60, 16, 0, 25'h1A5A5A5, -1);

        // Illegal regions, then a legal command is still accepted.
        illegal_cmd(3'd7);
        illegal_cmd(3'd6);
        load_region(5, 10, 1, 8, 0, 25'h1FFFFFF, -1);
        load_region(4, 60, 1, 9, 0, 25'h1FFFFFF, -1);
        check_output("mask_five_loaded", 32'(bus.loaded_mask), 32'h3D);
        check_output("err_sticky", 32'(bus.cmd_err), 32'd1);

        // conv2 kernels interrupted by reset at beat 500.
        load_region(1, 1080, 18, 25, 0, 25'h0F0F0F0, 500);

        // Load every region, then reload one.
        load_region(0, 90, 5, 25, 0, 25'h1234567, -1);
        load_region(1, 1080, 18, 25, 11, 25'h0F0F0F0, -1);
        load_region(2, 600, 60, 16, 0, 25'h1FFFFFF, -1);
        load_region(3, 18, 1, 7, 0, 25'h1FFFFFF, -1);
        load_region(4, 60, 1, 9, 0, 25'h0AAAAAA, -1);
        load_region(5, 10, 1, 8, 0, 25'h1555555, -1);
        check_output("all_loaded_mask", 32'(bus.loaded_mask), 32'h3F);
        check_output("all_params_ready", 32'(bus.params_ready), 32'd1);
        load_region(4, 60, 1, 9, 5, 25'h0123456, -1);
        check_output("reload_params_ready", 32'(bus.params_ready), 32'd1);

        $display("[TB] directed sequence complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bnn_param_loader.md
BNN_PARAM_LOADER -- requirements
Module: bnn_param_loader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- K, 5, kernel side
- C1_IN, 5, conv1 input slices per output channel
- C1_OUT, 18, conv1 output channels
- C2_OUT, 60, conv2 output channels
- FC_IN, 960, fc fan-in bits
- FC_OUT, 10, fc outputs
- FCB_W, 16, fc binary-weight bits per beat
- OFF1_W, 7, conv1 offset width
- OFF2_W, 9, conv2 offset width
- MULT_W, 8, fc multiplier width
- HI_W, 6, outer address width
- LO_W, 6, inner address width

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  sole clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  region command offered
- cmd_ready  out  1  command accepted when both high
- cmd_region  in  3  0=conv1 kernel, 1=conv2 kernel, 2=fc binary, 3=conv1 offset, 4=conv2 offset, 5=fc mult; 6 and 7 illegal
- in_valid  in  1  data beat offered
- in_ready  out  1  beat accepted when both high
- in_data  in  K*K  beat payload
- wr_en  out  1  memory write strobe
- wr_region  out  3  target region
- wr_hi  out  HI_W  outer index
- wr_lo  out  LO_W  inner index
- wr_data  out  K*K  write payload
- load_done  out  1  one-cycle pulse at region completion
- loaded_mask  out  6  per-region loaded flags
- params_ready  out  1  AND of loaded_mask
- cmd_err  out  1  sticky illegal-command flag

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD and DONE; cmd_ready SHALL equal (state==IDLE) and in_ready SHALL equal (state==LOAD).
REQ-004 A legal command accepted in IDLE SHALL move the FSM to LOAD, latch the region, clear the hi and lo counters, clear loaded_mask[region], and set the beat total N.
REQ-005 N per region SHALL be: 0 -> C1_OUT*C1_IN (90); 1 -> C2_OUT*C1_OUT (1080); 2 -> FC_OUT*FC_IN/FCB_W (600); 3 -> C1_OUT (18); 4 -> C2_OUT (60); 5 -> FC_OUT (10).
REQ-006 The lo wrap limit per region SHALL be: 0 -> C1_IN; 1 -> C1_OUT; 2 -> FC_IN/FCB_W; 3-5 -> 1, so lo stays 0.
REQ-007 On each accepted beat lo SHALL increment; at the wrap limit lo SHALL return to 0 and hi SHALL increment.
REQ-008 A beat accepted in cycle t SHALL produce wr_en=1 in cycle t+1 carrying that beat's region, hi, lo and payload; wr_en SHALL be 0 in every other cycle.
REQ-009 wr_data SHALL be in_data for regions 0 and 1, bits [FCB_W-1:0] for region 2, and bits [OFF1_W-1:0], [OFF2_W-1:0] or [MULT_W-1:0] for regions 3, 4 or 5; all unused upper bits SHALL be 0.
REQ-010 When the Nth beat is accepted in cycle t, the FSM SHALL enter DONE at t+1.
REQ-011 In that cycle t+1, load_done SHALL be 1 and loaded_mask[region] SHALL be set.
REQ-012 The FSM SHALL return to IDLE at t+2; no beat SHALL be accepted in DONE.
REQ-013 An illegal command (region 6 or 7) accepted in IDLE SHALL set cmd_err, SHALL leave the FSM in IDLE, and SHALL leave loaded_mask and the counters unchanged.
REQ-014 cmd_err SHALL clear only on rst.
REQ-015 in_valid while not in LOAD SHALL be ignored with no write; cmd_valid while not in IDLE SHALL stall the command.
REQ-016 A stall (in_valid=0) during LOAD SHALL hold the counters and produce no write, for any stall length.
REQ-017 Reloading an already-loaded region SHALL deassert params_ready from the accept cycle +1 until that reload's load_done cycle.
REQ-018 Counter widths SHALL be sized from the parameters so that no overflow occurs at the maximum N.

Reset
REQ-019 rst SHALL put the FSM in IDLE and set to 0 the counters, wr_en, wr_region, wr_hi, wr_lo, wr_data, load_done, loaded_mask, params_ready and cmd_err.
REQ-020 rst asserted mid-LOAD SHALL abandon the load; no write SHALL occur in the cycle after rst, and the region SHALL stay unloaded.
REQ-021 rst SHALL take priority over any simultaneous handshake.

Verification
REQ-022 Region 3, 18 back-to-back beats with in_data = i -> 18 writes with wr_hi = 0..17, wr_lo = 0, wr_data = i & 7'h7F; load_done one cycle after the last beat; loaded_mask = 6'b001000.
REQ-023 Region 0, 90 beats with random stalls -> wr_lo cycles 0..4 and wr_hi steps 0..17; exactly 90 writes; no write in any stall cycle.
REQ-024 Region 2, 600 beats -> wr_lo wraps at 59, wr_hi reaches 9, wr_data upper 9 bits are 0.
REQ-025 cmd_region = 7 -> cmd_err = 1, FSM stays IDLE, loaded_mask unchanged; a following legal command is still accepted.
REQ-026 rst at beat 500 of a region-1 load -> next cycle wr_en = 0, loaded_mask = 0, cmd_ready = 1.
REQ-027 Load all six regions -> params_ready = 1; reload region 4 -> params_ready = 0 until that reload's load_done.
